// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - burst memory protocol responder serving one read or write burst at a time from an on-chip RAM
module burst_mem_responder #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 25,
  parameter int BUSRT_BITS    = 10,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN, S_DONE, S_GAP
  } state_t;

  localparam logic [BUSRT_BITS-1:0]    BEAT_ONE = 1;
  localparam logic [RAM_ADDR_BITS-1:0] PTR_ONE  = 1;

  state_t                   state_q, state_d;
  logic [BUSRT_BITS-1:0]    cnt_q, cnt_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                     dir_wr_q, dir_wr_d;
  logic                     last_wr_q, last_wr_d;
  logic                     we_q, rd_pend_q, rd_valid_q, rd_fin_q, wr_fin_q;
  logic [MEM_DATA_BITS-1:0] rd_data_q, ram_rdata_q;
  logic                     grant_wr, re;
  logic                     unused_addr_bits;

  logic [MEM_DATA_BITS-1:0] mem [0:(1<<RAM_ADDR_BITS)-1];

  // Only the low RAM_ADDR_BITS of either address select a RAM word.
  assign unused_addr_bits = ^{rd_burst_addr, wr_burst_addr};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    dir_wr_d  = dir_wr_q;
    last_wr_d = last_wr_q;
    re        = 1'b0;
    grant_wr  = wr_burst_req && (!rd_burst_req || !last_wr_q);
    // Write beats land one cycle after their request, so ptr follows the write strobe.
    if (we_q) ptr_d = ptr_q + PTR_ONE;
    case (state_q)
      S_IDLE: begin
        if (wr_burst_req || rd_burst_req) begin
          dir_wr_d = grant_wr;
          if (wr_burst_req && rd_burst_req) last_wr_d = grant_wr;
          cnt_d = grant_wr ? wr_burst_len : rd_burst_len;
          ptr_d = grant_wr ? wr_burst_addr[RAM_ADDR_BITS-1:0]
                           : rd_burst_addr[RAM_ADDR_BITS-1:0];
          if (cnt_d == '0) state_d = S_DONE;
          else             state_d = grant_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (cnt_q != '0) cnt_d = cnt_q - BEAT_ONE;
        if (cnt_q <= BEAT_ONE) state_d = S_WR_DRAIN;
      end
      S_RD: begin
        re    = 1'b1;
        ptr_d = ptr_q + PTR_ONE;
        if (cnt_q != '0) cnt_d = cnt_q - BEAT_ONE;
        if (cnt_q <= BEAT_ONE) state_d = S_RD_DRAIN;
      end
      S_WR_DRAIN: state_d = S_DONE;
      S_RD_DRAIN: state_d = S_DONE;
      S_DONE:     state_d = S_GAP;
      S_GAP:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      dir_wr_q   <= 1'b0;
      last_wr_q  <= 1'b0;
      we_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_fin_q   <= 1'b0;
      wr_fin_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      dir_wr_q   <= dir_wr_d;
      last_wr_q  <= last_wr_d;
      we_q       <= (state_q == S_WR);
      rd_pend_q  <= re;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= ram_rdata_q;
      wr_fin_q   <= (state_q == S_DONE) && dir_wr_q;
      rd_fin_q   <= (state_q == S_DONE) && !dir_wr_q;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (we_q) mem[ptr_q] <= wr_burst_data;
    if (re)   ram_rdata_q <= mem[ptr_q];
  end

  assign busy                = (state_q != S_IDLE);
  assign wr_burst_data_req   = (state_q == S_WR);
  assign rd_burst_data_valid = rd_valid_q;
  assign rd_burst_data       = rd_data_q;
  assign rd_burst_finish     = rd_fin_q;
  assign wr_burst_finish     = wr_fin_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed bench acting as both burst requesters
module tb_burst_mem_responder;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [24:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [24:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        busy;

  always #5 mem_clk = ~mem_clk;

  burst_mem_responder dut (
    .mem_clk             (mem_clk),
    .rst_n               (rst_n),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish),
    .busy                (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] wbuf [0:15];
  int          n_dreq, nvalid, vfirst, vlast, wfin_cnt, rfin_cnt, wfin_cyc, rfin_cyc, idle_cyc;
  logic [63:0] rq [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    rd_burst_req  = 1'b0;
    wr_burst_req  = 1'b0;
    rd_burst_len  = '0;
    wr_burst_len  = '0;
    rd_burst_addr = '0;
    wr_burst_addr = '0;
    wr_burst_data = '0;
    repeat (2) @(posedge mem_clk);
    #1 rst_n = 1'b1;
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_wbuf(input logic [63:0] base);
    for (int i = 0; i < 16; i++) wbuf[i] = base + 64'(i);
  endtask

  // cyc counts clock edges since the grant edge (cyc 0); sampled 1 time unit after each edge.
  task automatic run(input bit dw, input bit dr,
                     input logic [24:0] wa, input logic [9:0] wl,
                     input logic [24:0] ra, input logic [9:0] rl);
    bit wpend;
    bit done;
    int widx;
    n_dreq = 0; nvalid = 0; wfin_cnt = 0; rfin_cnt = 0;
    vfirst = -1; vlast = -1; wfin_cyc = -1; rfin_cyc = -1; idle_cyc = -1;
    rq.delete();
    wpend = 1'b0; done = 1'b0; widx = 0;
    wr_burst_req = dw; wr_burst_addr = wa; wr_burst_len = wl;
    rd_burst_req = dr; rd_burst_addr = ra; rd_burst_len = rl;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(posedge mem_clk);
      #1;
      if (wpend && widx < 16) begin
        wr_burst_data = wbuf[widx];
        widx++;
      end
      wpend = wr_burst_data_req;
      if (wr_burst_data_req) n_dreq++;
      if (rd_burst_data_valid) begin
        if (vfirst < 0) vfirst = cyc;
        vlast = cyc;
        nvalid++;
        rq.push_back(rd_burst_data);
      end
      if (wr_burst_finish) begin
        if (wfin_cnt == 0) wfin_cyc = cyc;
        wfin_cnt++;
        wr_burst_req = 1'b0;
      end
      if (rd_burst_finish) begin
        if (rfin_cnt == 0) rfin_cyc = cyc;
        rfin_cnt++;
        rd_burst_req = 1'b0;
      end
      if ((!dw || wfin_cnt > 0) && (!dr || rfin_cnt > 0) && !busy) begin
        done = 1'b1;
        idle_cyc = cyc;
      end
    end
    check("burst_done_in_budget", 64'(done), 64'd1);
    wr_burst_req = 1'b0;
    rd_burst_req = 1'b0;
  endtask

  task automatic check_reads(input string tag, input int n, input logic [63:0] base);
    logic [63:0] got;
    check({tag, "_nvalid"}, 64'(nvalid), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < rq.size()) ? rq[i] : 'x;
      check({tag, "_beat"}, got, base + 64'(i));
    end
  endtask

  initial begin
    bit wpend;
    int widx;
    int fin_seen;

    apply_reset();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data_req", 64'(wr_burst_data_req), 64'd0);
    check("rst_rd_valid", 64'(rd_burst_data_valid), 64'd0);
    check("rst_rd_data", rd_burst_data, 64'd0);
    check("rst_rd_finish", 64'(rd_burst_finish), 64'd0);
    check("rst_wr_finish", 64'(wr_burst_finish), 64'd0);

    // Write len 4 at 0x10 then read it back
    set_wbuf(64'hA0);
    run(1'b1, 1'b0, 25'h10, 10'd4, 25'h0, 10'd0);
    check("wr4_data_req_cycles", 64'(n_dreq), 64'd4);
    check("wr4_finish_pulses", 64'(wfin_cnt), 64'd1);
    check("wr4_finish_latency", 64'(wfin_cyc), 64'd6);
    check("wr4_idle_after_gap", 64'(idle_cyc), 64'd7);

    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h10, 10'd4);
    check_reads("rd4", 4, 64'hA0);
    check("rd4_first_valid", 64'(vfirst), 64'd2);
    check("rd4_contiguous", 64'(vlast - vfirst), 64'd3);
    check("rd4_finish_latency", 64'(rfin_cyc), 64'd6);
    check("rd4_finish_after_last_valid", 64'(rfin_cyc - vlast), 64'd1);
    check("rd4_finish_pulses", 64'(rfin_cnt), 64'd1);
    check("rd4_data_held", rd_burst_data, 64'hA3);

    // Simultaneous requests straight after reset: write wins, then round-robin gives read
    apply_reset();
    set_wbuf(64'hC0);
    run(1'b1, 1'b1, 25'h20, 10'd2, 25'h20, 10'd2);
    check("tie1_wr_finish", 64'(wfin_cyc), 64'd4);
    check("tie1_rd_finish", 64'(rfin_cyc), 64'd10);
    check_reads("tie1_rd", 2, 64'hC0);

    set_wbuf(64'hD0);
    run(1'b1, 1'b1, 25'h20, 10'd2, 25'h20, 10'd2);
    check("tie2_rd_finish", 64'(rfin_cyc), 64'd4);
    check("tie2_wr_finish", 64'(wfin_cyc), 64'd10);
    check_reads("tie2_rd_old", 2, 64'hC0);

    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h20, 10'd2);
    check_reads("tie2_rd_new", 2, 64'hD0);

    // Wrap at the top of the RAM, and upper address bits ignored
    set_wbuf(64'hE0);
    run(1'b1, 1'b0, 25'h3FF, 10'd3, 25'h0, 10'd0);
    check("wrap_wr_data_req_cycles", 64'(n_dreq), 64'd3);
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h3FF, 10'd3);
    check_reads("wrap_rd", 3, 64'hE0);
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h1000000, 10'd1);
    check_reads("wrap_addr0", 1, 64'hE1);
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h0001, 10'd1);
    check_reads("wrap_addr1", 1, 64'hE2);

    // Zero-length bursts
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h10, 10'd0);
    check("len0_rd_nvalid", 64'(nvalid), 64'd0);
    check("len0_rd_finish", 64'(rfin_cyc), 64'd1);
    check("len0_rd_pulses", 64'(rfin_cnt), 64'd1);
    check("len0_rd_idle", 64'(idle_cyc), 64'd2);
    run(1'b1, 1'b0, 25'h10, 10'd0, 25'h0, 10'd0);
    check("len0_wr_data_req", 64'(n_dreq), 64'd0);
    check("len0_wr_finish", 64'(wfin_cyc), 64'd1);
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h10, 10'd1);
    check_reads("len0_wr_no_write", 1, 64'hA0);

    // Reset during beat 2 of a len 8 write
    set_wbuf(64'hEE);
    run(1'b1, 1'b0, 25'h42, 10'd2, 25'h0, 10'd0);
    set_wbuf(64'hB0);
    wpend = 1'b0;
    widx  = 0;
    wr_burst_req = 1'b1; wr_burst_addr = 25'h40; wr_burst_len = 10'd8;
    for (int c = 0; c < 4; c++) begin
      @(posedge mem_clk);
      #1;
      if (wpend) begin
        wr_burst_data = wbuf[widx];
        widx++;
      end
      wpend = wr_burst_data_req;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_data_req", 64'(wr_burst_data_req), 64'd0);
    check("midrst_rd_valid", 64'(rd_burst_data_valid), 64'd0);
    check("midrst_rd_data", rd_burst_data, 64'd0);
    check("midrst_wr_finish", 64'(wr_burst_finish), 64'd0);
    wr_burst_req = 1'b0;
    fin_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge mem_clk);
      #1;
      if (wr_burst_finish || rd_burst_finish) fin_seen++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge mem_clk);
      #1;
      if (wr_burst_finish || rd_burst_finish || busy) fin_seen++;
    end
    check("midrst_no_finish", 64'(fin_seen), 64'd0);
    run(1'b0, 1'b1, 25'h0, 10'd0, 25'h40, 10'd3);
    check("midrst_rd_nvalid", 64'(nvalid), 64'd3);
    check("midrst_beat0", (rq.size() > 0) ? rq[0] : 64'hx, 64'hB0);
    check("midrst_beat1", (rq.size() > 1) ? rq[1] : 64'hx, 64'hB1);
    check("midrst_beat2_not_written", (rq.size() > 2) ? rq[2] : 64'hx, 64'hEE);
    check("midrst_rd_finish", 64'(rfin_cyc), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
